// File: rtl/pattern_serializer.sv
// pattern_serializer: valid/ready word-to-bit serializer that feeds a single-bit detector input,
// with selectable bit order, a fixed idle level and an optional idle gap after each word.
module pattern_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   LSB_FIRST = 0,
    parameter int   GAP       = 0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, SHIFT, GAPS} state_t;
    state_t         state_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]  cnt_q;
    logic [3:0]     gap_q;
    logic           live_q;
    logic           last;
    logic           accept;
    assign last     = state_q == SHIFT && cnt_q == CW'(WIDTH - 1);
    // live_q holds in_ready low until the first edge after reset release
    assign in_ready = live_q && (state_q == IDLE || (last && GAP == 0));
    assign accept   = in_valid && in_ready;
    // dout carries the bit already taken off the shift register, so the first bit leaves on the accept edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            live_q     <= 1'b0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            word_done <= 1'b0;
            if (accept) begin
                state_q    <= SHIFT;
                sr_q       <= LSB_FIRST != 0 ? in_data >> 1 : in_data << 1;
                cnt_q      <= '0;
                dout       <= LSB_FIRST != 0 ? in_data[0] : in_data[WIDTH-1];
                dout_valid <= 1'b1;
                busy       <= 1'b1;
            end else if (state_q == SHIFT && !last) begin
                sr_q      <= LSB_FIRST != 0 ? sr_q >> 1 : sr_q << 1;
                cnt_q     <= cnt_q + 1'b1;
                dout      <= LSB_FIRST != 0 ? sr_q[0] : sr_q[WIDTH-1];
                word_done <= cnt_q == CW'(WIDTH - 2);
            end else if (last && GAP > 0) begin
                state_q    <= GAPS;
                gap_q      <= 4'(GAP);
                dout       <= IDLE_BIT;
                dout_valid <= 1'b0;
                busy       <= 1'b1;
            end else if (state_q == GAPS && gap_q > 4'd1) begin
                gap_q <= gap_q - 4'd1;
            end else begin
                state_q    <= IDLE;
                dout       <= IDLE_BIT;
                dout_valid <= 1'b0;
                busy       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: three serializer configurations checked cycle by cycle against
// a timeline model built from accepted words, with directed and random stimulus.
module tb_pattern_serializer;
    localparam int NC = 4096;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int  mw[3] = '{8, 8, 4};
    int  mg[3] = '{0, 2, 3};
    bit  ml[3] = '{1'b0, 1'b0, 1'b1};
    bit  mi[3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] nd[3];
    logic       nv[3];
    logic       rdy_o[3], do_o[3], dv_o[3], wd_o[3], bz_o[3];
    bit e_do[3][NC], e_dv[3][NC], e_wd[3][NC], e_bz[3][NC];
    int ready_from[3] = '{0, 0, 0};
    logic [7:0] dw[3][2];
    int dn[3] = '{0, 0, 0};
    int dp[3] = '{0, 0, 0};
    bit rnd = 1'b0;
    bit cap_en = 1'b0;
    logic [15:0] cap = '0;

    pattern_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(0), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .reset(reset), .in_data(nd[0]), .in_valid(nv[0]), .in_ready(rdy_o[0]),
        .dout(do_o[0]), .dout_valid(dv_o[0]), .word_done(wd_o[0]), .busy(bz_o[0]));
    pattern_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(2), .IDLE_BIT(1'b0)) u1 (
        .clk(clk), .reset(reset), .in_data(nd[1]), .in_valid(nv[1]), .in_ready(rdy_o[1]),
        .dout(do_o[1]), .dout_valid(dv_o[1]), .word_done(wd_o[1]), .busy(bz_o[1]));
    pattern_serializer #(.WIDTH(4), .LSB_FIRST(1), .GAP(3), .IDLE_BIT(1'b1)) u2 (
        .clk(clk), .reset(reset), .in_data(nd[2][3:0]), .in_valid(nv[2]), .in_ready(rdy_o[2]),
        .dout(do_o[2]), .dout_valid(dv_o[2]), .word_done(wd_o[2]), .busy(bz_o[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit rdy(int i);
        return reset && cyc >= ready_from[i];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < NC; k++) begin
                e_do[i][k] = mi[i];
                e_dv[i][k] = 1'b0;
                e_wd[i][k] = 1'b0;
                e_bz[i][k] = 1'b0;
            end
    endtask

    // A word accepted in cycle c occupies cycles c+1..c+W, then GAP idle cycles.
    task automatic record(input int i, input logic [7:0] d);
        int w;
        w = mw[i];
        for (int k = 0; k < w; k++) begin
            e_dv[i][cyc+1+k] = 1'b1;
            e_do[i][cyc+1+k] = ml[i] ? d[k] : d[w-1-k];
            e_wd[i][cyc+1+k] = (k == w - 1);
            e_bz[i][cyc+1+k] = 1'b1;
        end
        for (int g = 1; g <= mg[i]; g++) e_bz[i][cyc+w+g] = 1'b1;
        ready_from[i] = cyc + w + (mg[i] > 0 ? mg[i] + 1 : 0);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (cyc > NC - 40) begin
            $display("FAIL budget cyc=%0d got=%0d exp=%0d", cyc, cyc, NC - 40);
            $fatal(1, "cycle budget exceeded");
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dout%0d", i), do_o[i], e_do[i][cyc]);
            chk($sformatf("dvalid%0d", i), dv_o[i], e_dv[i][cyc]);
            chk($sformatf("wdone%0d", i), wd_o[i], e_wd[i][cyc]);
            chk($sformatf("busy%0d", i), bz_o[i], e_bz[i][cyc]);
            chk($sformatf("ready%0d", i), rdy_o[i], rdy(i));
        end
        if (cap_en && dv_o[0]) cap = {cap[14:0], do_o[0]};
        for (int i = 0; i < 3; i++) begin
            if (dp[i] < dn[i]) begin
                nv[i] = 1'b1;
                nd[i] = dw[i][dp[i]];
            end else begin
                nv[i] = rnd && ($urandom_range(2) != 0);
                nd[i] = 8'($urandom);
            end
            if (nv[i] && rdy(i)) begin
                record(i, nd[i]);
                if (dp[i] < dn[i]) dp[i]++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        cyc++;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) nv[i] = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_dout%0d", i), do_o[i], mi[i]);
            chk($sformatf("rst_dvalid%0d", i), dv_o[i], 1'b0);
            chk($sformatf("rst_busy%0d", i), bz_o[i], 1'b0);
            chk($sformatf("rst_ready%0d", i), rdy_o[i], 1'b0);
            chk($sformatf("rst_wdone%0d", i), wd_o[i], 1'b0);
        end
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b1;
        clear_model();
        for (int i = 0; i < 3; i++) ready_from[i] = cyc + 1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            nv[i] = 1'b0;
            nd[i] = '0;
        end
        clear_model();
        do_reset(2);
        dw[0][0] = 8'hB0; dn[0] = 1;
        dw[1][0] = 8'hA5; dw[1][1] = 8'h3C; dn[1] = 2;
        dw[2][0] = 8'h0D; dn[2] = 1;
        repeat (30) step();
        chk("dir_acc0", dp[0], 1);
        chk("dir_acc1", dp[1], 2);
        chk("dir_acc2", dp[2], 1);
        dp[0] = 0; dw[0][0] = 8'hA5; dw[0][1] = 8'h3C; dn[0] = 2;
        dn[1] = 0; dn[2] = 0;
        cap = '0;
        cap_en = 1'b1;
        repeat (22) step();
        cap_en = 1'b0;
        chk("b2b_bits", cap, 16'hA53C);
        dp[0] = 0; dw[0][0] = 8'hFF; dn[0] = 1;
        for (int t = 0; t < 10 && dp[0] == 0; t++) step();
        chk("ff_accepted", dp[0], 1);
        repeat (3) step();
        do_reset(2);
        dn[0] = 0;
        repeat (15) step();
        rnd = 1'b1;
        repeat (600) step();
        do_reset(1);
        repeat (600) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Parallel-to-serial front end that feeds the pattern detector's single-bit `din` input, one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out with a programmable bit order.
- Inserts a programmable idle gap between words and drives a fixed idle level when no word is queued.
- Lets the detector be exercised from a word-oriented source (bus, FIFO, test stimulus) without changing the detector.

Parameters:
- WIDTH, 8, bits per input word (WIDTH >= 2).
- LSB_FIRST, 0, 0 = shift MSB first, 1 = shift LSB first.
- GAP, 0, number of idle-bit cycles inserted after each word (0..15).
- IDLE_BIT, 0, value driven on dout when not shifting.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset: asserts immediately when low, releases synchronously to clk.
- in_data  input  WIDTH  parallel word; sampled only on accept.
- in_valid  input  1  source has a word.
- in_ready  output  1  serializer can take a word this cycle.
- dout  output  1  serial bit to the detector's din.
- dout_valid  output  1  high while dout carries a data bit; low for idle or gap bits.
- word_done  output  1  one-cycle pulse coincident with the last data bit of a word.
- busy  output  1  high in SHIFT or GAP.

Behaviour:
- Reset values (reset low): state = IDLE, shift register = 0, bit counter = 0, gap counter = 0, dout = IDLE_BIT, dout_valid = 0, word_done = 0, busy = 0, in_ready = 0.
  - in_ready goes to 1 on the first clock edge after reset releases.
  - dout, dout_valid, word_done and busy are registered outputs. in_ready is combinational from state and counters only, never from in_valid.
- Accept: occurs on a clock edge where in_valid && in_ready.
  - in_data is loaded into the shift register.
  - Changes to in_data while in_ready = 0 have no effect.
- States:
  - IDLE: in_ready = 1, dout = IDLE_BIT, dout_valid = 0. Accept -> SHIFT.
  - SHIFT: each cycle drives the next bit, MSB-first or LSB-first per LSB_FIRST, with dout_valid = 1. The bit counter runs 0..WIDTH-1.
    - On the bit WIDTH-1 cycle, word_done = 1.
    - Exit then: GAP when GAP > 0; otherwise SHIFT again if an accept occurs, else IDLE.
  - GAP: drives dout = IDLE_BIT, dout_valid = 0 for exactly GAP cycles, then -> IDLE. in_ready = 0 throughout GAP.
- Latency: the first bit of an accepted word appears on dout in the cycle after the accept edge. Bit k appears k+1 cycles after accept.
- Back-to-back (GAP = 0): in_ready = 1 during the cycle dout carries bit WIDTH-1.
  - An accept on that edge puts bit 0 of the next word on dout on the very next cycle.
  - Result is zero bubbles and a continuous dout_valid.
- in_ready = 0 in SHIFT except on the last-bit cycle. This avoids overrun; there is no internal buffer beyond the shift register.
- Reset mid-word: the current and any pending word are discarded. After release, return to IDLE with dout = IDLE_BIT; the word is not resumed.
- Bit counter width is clog2(WIDTH); it wraps to 0 on load.
- The gap counter is 4 bits and loads GAP on entry to GAP.

Test Plan:
- Reset release, accept in_data = 8'b1011_0000 (MSB first) -> dout on cycles 1..8 after accept = 1,0,1,1,0,0,0,0; dout_valid high on cycles 1..8; word_done on cycle 8; then dout = 0, dout_valid = 0, busy = 0, in_ready = 1.
- GAP = 0, in_valid held high with words 8'hA5 then 8'h3C -> 16 contiguous valid bits 1010_0101_0011_1100; in_ready high only on cycle 8 of the first word; no idle cycle between words.
- GAP = 2, same two words -> 8 data bits, 2 cycles dout = IDLE_BIT with dout_valid = 0, 1 IDLE cycle with in_ready = 1, then second word; in_ready = 0 during both gap cycles.
- Accept 8'hFF, pull reset low after 3 bits, hold 2 cycles, release -> dout = IDLE_BIT and busy = 0 immediately on reset assertion; no remaining 1s emitted; in_ready = 1 on the first edge after release.
- in_valid high while busy, with in_data changing every cycle -> none of the changes are loaded; only the value present at the in_ready && in_valid edge is serialized.
- LSB_FIRST = 1, WIDTH = 4, in_data = 4'b1101 -> dout = 1,0,1,1; with the detector attached downstream, its detect output pulses one cycle after the final 1.
